l1_wb_reg_slave: RTL and testbench
==================================

# l1_wb_reg_slave

Wishbone B4 pipelined slave front-end for the L1 cache register block. It accepts single-beat register reads and writes from the system bus, decodes and checks each address against the L1 register window, and hands legal accesses to the register block over a simple request/acknowledge port. It returns ack or err to the bus master, and converts a stuck register-side access into a bus error through a timeout counter.

## Interface
- `BASE_ADDR`, 32'h0000_1000: byte address of register 0.
- `NREGS`, 8: number of 32-bit registers in the window.
- `TIMEOUT`, 16: maximum cycles to wait for `reg_ack_i`.
- `wb_clk_i`  in  1: the single clock.
- `wb_rst_i`  in  1: asynchronous, active-high reset.
- `wb_cyc_i`  in  1: bus cycle valid.
- `wb_stb_i`  in  1: request strobe.
- `wb_we_i`  in  1: 1 = write.
- `wb_adr_i`  in  32: byte address.
- `wb_dat_i`  in  32: write data.
- `wb_sel_i`  in  4: byte enables.
- `wb_dat_o`  out  32: read data, valid with `wb_ack_o`.
- `wb_ack_o`  out  1: one-cycle completion pulse.
- `wb_err_o`  out  1: one-cycle error pulse.
- `wb_stall_o`  out  1: slave cannot accept a request.
- `reg_req_o`  out  1: register access request.
- `reg_we_o`  out  1: write flag.
- `reg_idx_o`  out  clog2(NREGS): register index.
- `reg_wdata_o`  out  32: write data.
- `reg_be_o`  out  4: byte enables.
- `reg_rdata_i`  in  32: read data, sampled with `reg_ack_i`.
- `reg_ack_i`  in  1: register block completed the request.

## Operation
- **Acceptance.** A request is accepted on a rising edge where `wb_cyc_i & wb_stb_i & !wb_stall_o`. Only one access is outstanding at a time.
- **States.**
  - IDLE -> REG: request accepted and legal.
  - IDLE -> ERR: request accepted and illegal.
  - REG -> RESP: `reg_ack_i` seen.
  - REG -> ERR: timeout expired.
  - RESP -> IDLE and ERR -> IDLE: unconditional, after one cycle.
- **Legality.** A request is legal when `BASE_ADDR <= adr < BASE_ADDR + 4*NREGS` and `adr[1:0] == 0`.
  - `reg_idx_o = (adr - BASE_ADDR) >> 2`, truncated to the index width.
  - A write with `wb_sel_i == 0` is legal. It skips REG and goes IDLE -> RESP with no `reg_req_o`.
- **REG state.**
  - `reg_req_o = 1`. `reg_we_o`, `reg_idx_o`, `reg_wdata_o` and `reg_be_o` are registered at acceptance and held stable until the request ends.
  - On `reg_ack_i`, `reg_rdata_i` is captured into `wb_dat_o` for reads. On writes, `wb_dat_o` is 0.
- **Timeout counter.**
  - Cleared on entry to REG and incremented each REG cycle without `reg_ack_i`.
  - When the count reaches `TIMEOUT - 1` with no ack, the FSM moves to ERR and `reg_req_o` drops.
  - A `reg_ack_i` arriving while not in REG is ignored.
- **RESP state:** `wb_ack_o = 1` for one cycle. **ERR state:** `wb_err_o = 1` for one cycle with `wb_dat_o = 0`. `wb_ack_o` and `wb_err_o` are never both high.
- **Stall.** `wb_stall_o` is high in every state except IDLE.
- **Abort.** If `wb_cyc_i` drops while in REG, the register access still completes; the following RESP or ERR pulse is suppressed.
- **Reset.**
  - All outputs go to 0 and the FSM goes to IDLE.
  - `reg_req_o` and `wb_stall_o` clear asynchronously, including when reset asserts mid-access.
  - The register block treats a dropped `reg_req_o` as a cancelled request.

## Timing
- Accept on edge t. `reg_req_o` is high from t+1.
- If `reg_ack_i` is high in cycle t+k (k >= 1), `wb_ack_o` is high in cycle t+k+1. Minimum latency from accept to ack is 2 cycles.
- Illegal address: `wb_err_o` is high in t+1. No `reg_req_o` is issued.
- Zero-select write: `wb_ack_o` is high in t+1.
- Timeout: `reg_req_o` is high for exactly `TIMEOUT` cycles, from t+1 to t+TIMEOUT. `wb_err_o` is high in t+TIMEOUT+1.
- Back-to-back: the next request can be accepted in the cycle after the response pulse, when `wb_stall_o` is 0. Best-case throughput is one access per 3 cycles.

## Test plan
- Write `adr = 32'h1008`, `dat = 32'hDEAD_BEEF`, `sel = 4'hF`; register side acks at k=1.
  - Expect `reg_idx_o = 2`, `reg_we_o = 1`, `reg_wdata_o = 32'hDEAD_BEEF`.
  - Expect `wb_ack_o` 2 cycles after accept and `wb_stall_o` high for 2 cycles.
- Read `adr = 32'h101C`; register side acks at k=5 with `reg_rdata_i = 32'h0000_1234`.
  - Expect `reg_idx_o = 7`.
  - Expect `wb_dat_o = 32'h1234` with `wb_ack_o` 6 cycles after accept.
- Illegal requests: reads to `adr = 32'h1020`, `32'h0FFC` and `32'h1002`.
  - Expect `wb_err_o` 1 cycle after accept for each.
  - Expect `reg_req_o` never asserted.
- Read `adr = 32'h1000` with `reg_ack_i` held 0.
  - Expect `reg_req_o` high for 16 cycles, then `wb_err_o` one cycle later with `wb_dat_o = 0`.
  - Then drive a late `reg_ack_i` pulse: expect no response.
- Read outstanding; drop `wb_cyc_i` at k=2; ack at k=3.
  - Expect no `wb_ack_o` and return to IDLE.
- Assert `wb_rst_i` for 1 cycle while in REG.
  - Expect `reg_req_o = 0` and `wb_stall_o = 0` in the same cycle.
  - Expect the next legal write to complete normally.

Source files
------------

// File: rtl/l1_wb_reg_slave_if.sv
// Wishbone B4 pipelined bus plus register-block request port
// for the L1 register slave.
interface l1_wb_reg_slave_if #(
  parameter int NREGS = 8
);
  localparam int IW = (NREGS > 1) ? $clog2(NREGS) : 1;

  logic          wb_cyc_i;
  logic          wb_stb_i;
  logic          wb_we_i;
  logic [31:0]   wb_adr_i;
  logic [31:0]   wb_dat_i;
  logic [3:0]    wb_sel_i;
  logic [31:0]   wb_dat_o;
  logic          wb_ack_o;
  logic          wb_err_o;
  logic          wb_stall_o;
  logic          reg_req_o;
  logic          reg_we_o;
  logic [IW-1:0] reg_idx_o;
  logic [31:0]   reg_wdata_o;
  logic [3:0]    reg_be_o;
  logic [31:0]   reg_rdata_i;
  logic          reg_ack_i;

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i,
    input  wb_adr_i, wb_dat_i, wb_sel_i,
    output wb_dat_o, wb_ack_o, wb_err_o,
    output wb_stall_o,
    output reg_req_o, reg_we_o, reg_idx_o,
    output reg_wdata_o, reg_be_o,
    input  reg_rdata_i, reg_ack_i
  );

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i,
    output wb_adr_i, wb_dat_i, wb_sel_i,
    input  wb_dat_o, wb_ack_o, wb_err_o,
    input  wb_stall_o,
    input  reg_req_o, reg_we_o, reg_idx_o,
    input  reg_wdata_o, reg_be_o,
    output reg_rdata_i, reg_ack_i
  );
endinterface

// File: rtl/l1_wb_reg_slave.sv
// Wishbone slave front-end for the L1 register block: decode,
// one outstanding access, ack/err return and register-side timeout.
module l1_wb_reg_slave #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
  parameter int          NREGS     = 8,
  parameter int          TIMEOUT   = 16
) (
  input logic               wb_clk_i,
  input logic               wb_rst_i,
  l1_wb_reg_slave_if.slave  bus
);

  localparam int IW = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
  localparam logic [32:0] LIMIT =
    {1'b0, BASE_ADDR} + 33'(4 * NREGS);

  typedef enum logic [1:0] {
    IDLE, REG, RESP, ERR
  } state_t;

  state_t        state_q, state_d;
  logic          we_q;
  logic [IW-1:0] idx_q;
  logic [31:0]   wdata_q;
  logic [3:0]    be_q;
  logic [31:0]   dat_q;
  logic [TW-1:0] cnt_q;
  logic          abort_q;

  logic        accept;
  logic        legal;
  logic [31:0] off;

  assign off    = bus.wb_adr_i - BASE_ADDR;
  assign accept = (state_q == IDLE) &
                  bus.wb_cyc_i & bus.wb_stb_i;
  assign legal  = (bus.wb_adr_i >= BASE_ADDR) &
                  ({1'b0, bus.wb_adr_i} < LIMIT) &
                  (bus.wb_adr_i[1:0] == 2'b00);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (!legal)
            state_d = ERR;
          else if (bus.wb_we_i && bus.wb_sel_i == 4'h0)
            state_d = RESP;
          else
            state_d = REG;
        end
      end
      REG: begin
        if (bus.reg_ack_i)
          state_d = RESP;
        else if (cnt_q == TO_LAST)
          state_d = ERR;
      end
      RESP:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request fields freeze at acceptance; abort remembers a dropped cycle.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      dat_q   <= '0;
      cnt_q   <= '0;
      abort_q <= 1'b0;
    end else if (accept) begin
      abort_q <= 1'b0;
      dat_q   <= '0;
      cnt_q   <= '0;
      if (legal) begin
        we_q    <= bus.wb_we_i;
        idx_q   <= IW'(off >> 2);
        wdata_q <= bus.wb_dat_i;
        be_q    <= bus.wb_sel_i;
      end
    end else if (state_q == REG) begin
      if (!bus.wb_cyc_i)
        abort_q <= 1'b1;
      if (bus.reg_ack_i)
        dat_q <= we_q ? 32'h0 : bus.reg_rdata_i;
      else
        cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.wb_stall_o  = (state_q != IDLE);
  assign bus.reg_req_o   = (state_q == REG);
  assign bus.wb_ack_o    = (state_q == RESP) & ~abort_q;
  assign bus.wb_err_o    = (state_q == ERR) & ~abort_q;
  assign bus.wb_dat_o    = bus.wb_ack_o ? dat_q : 32'h0;
  assign bus.reg_we_o    = we_q;
  assign bus.reg_idx_o   = idx_q;
  assign bus.reg_wdata_o = wdata_q;
  assign bus.reg_be_o    = be_q;

endmodule

// File: tb/tb_l1_wb_reg_slave.sv
// Directed bench for l1_wb_reg_slave: writes, reads, decode errors,
// timeout, abort and mid-access reset.
module tb_l1_wb_reg_slave;

  logic clk;
  logic rst;
  int   nvec;
  int   nbad;
  int   n;

  l1_wb_reg_slave_if #(.NREGS(8)) bus ();

  l1_wb_reg_slave #(
    .BASE_ADDR (32'h0000_1000),
    .NREGS     (8),
    .TIMEOUT   (16)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nbad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic we, input logic [31:0] adr,
                     input logic [31:0] dat, input logic [3:0] sel);
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    bus.wb_we_i  = we;
    bus.wb_adr_i = adr;
    bus.wb_dat_i = dat;
    bus.wb_sel_i = sel;
    tick();
    bus.wb_stb_i = 1'b0;
  endtask

  initial begin
    nvec = 0;
    nbad = 0;
    rst  = 1'b1;
    bus.wb_cyc_i    = 1'b0;
    bus.wb_stb_i    = 1'b0;
    bus.wb_we_i     = 1'b0;
    bus.wb_adr_i    = '0;
    bus.wb_dat_i    = '0;
    bus.wb_sel_i    = '0;
    bus.reg_rdata_i = '0;
    bus.reg_ack_i   = 1'b0;
    tick();
    tick();
    chk("rst_stall", 32'(bus.wb_stall_o), 32'h0);
    chk("rst_req",   32'(bus.reg_req_o),  32'h0);
    chk("rst_ack",   32'(bus.wb_ack_o),   32'h0);
    chk("rst_err",   32'(bus.wb_err_o),   32'h0);
    chk("rst_dat",   bus.wb_dat_o,        32'h0);
    rst = 1'b0;
    tick();

    // write, acked at k=1
    req(1'b1, 32'h1008, 32'hDEAD_BEEF, 4'hF);
    chk("wr_req",   32'(bus.reg_req_o),  32'h1);
    chk("wr_idx",   32'(bus.reg_idx_o),  32'h2);
    chk("wr_we",    32'(bus.reg_we_o),   32'h1);
    chk("wr_wdata", bus.reg_wdata_o,     32'hDEAD_BEEF);
    chk("wr_be",    32'(bus.reg_be_o),   32'hF);
    chk("wr_stall1",32'(bus.wb_stall_o), 32'h1);
    chk("wr_ack1",  32'(bus.wb_ack_o),   32'h0);
    bus.reg_ack_i = 1'b1;
    tick();
    bus.reg_ack_i = 1'b0;
    chk("wr_ack",   32'(bus.wb_ack_o),   32'h1);
    chk("wr_stall2",32'(bus.wb_stall_o), 32'h1);
    chk("wr_dat",   bus.wb_dat_o,        32'h0);
    chk("wr_req2",  32'(bus.reg_req_o),  32'h0);
    tick();
    chk("wr_idle",  32'(bus.wb_stall_o), 32'h0);
    chk("wr_ackoff",32'(bus.wb_ack_o),   32'h0);

    // read, acked at k=5
    req(1'b0, 32'h101C, 32'h0, 4'hF);
    chk("rd_idx", 32'(bus.reg_idx_o), 32'h7);
    chk("rd_we",  32'(bus.reg_we_o),  32'h0);
    for (int k = 1; k < 5; k++) begin
      chk("rd_wait", 32'(bus.wb_ack_o), 32'h0);
      tick();
    end
    chk("rd_req5", 32'(bus.reg_req_o), 32'h1);
    bus.reg_ack_i   = 1'b1;
    bus.reg_rdata_i = 32'h0000_1234;
    tick();
    bus.reg_ack_i   = 1'b0;
    bus.reg_rdata_i = 32'h0;
    chk("rd_ack", 32'(bus.wb_ack_o), 32'h1);
    chk("rd_dat", bus.wb_dat_o,      32'h1234);
    tick();
    bus.wb_cyc_i = 1'b0;

    // illegal addresses
    req(1'b0, 32'h1020, 32'h0, 4'hF);
    chk("il_hi_err", 32'(bus.wb_err_o),  32'h1);
    chk("il_hi_req", 32'(bus.reg_req_o), 32'h0);
    chk("il_hi_ack", 32'(bus.wb_ack_o),  32'h0);
    tick();
    req(1'b0, 32'h0FFC, 32'h0, 4'hF);
    chk("il_lo_err", 32'(bus.wb_err_o),  32'h1);
    chk("il_lo_req", 32'(bus.reg_req_o), 32'h0);
    tick();
    req(1'b0, 32'h1002, 32'h0, 4'hF);
    chk("il_un_err", 32'(bus.wb_err_o),  32'h1);
    chk("il_un_req", 32'(bus.reg_req_o), 32'h0);
    tick();
    chk("il_idle", 32'(bus.wb_err_o), 32'h0);

    // zero-select write completes without a register request
    req(1'b1, 32'h1018, 32'h1111_2222, 4'h0);
    chk("zs_ack", 32'(bus.wb_ack_o),  32'h1);
    chk("zs_req", 32'(bus.reg_req_o), 32'h0);
    tick();

    // timeout
    req(1'b0, 32'h1000, 32'h0, 4'hF);
    n = 0;
    while (bus.reg_req_o && n < 40) begin
      n++;
      tick();
    end
    chk("to_len", 32'(n),             32'd16);
    chk("to_err", 32'(bus.wb_err_o),  32'h1);
    chk("to_ack", 32'(bus.wb_ack_o),  32'h0);
    chk("to_dat", bus.wb_dat_o,       32'h0);
    tick();
    bus.wb_cyc_i  = 1'b0;
    bus.reg_ack_i = 1'b1;
    tick();
    bus.reg_ack_i = 1'b0;
    chk("late_ack",   32'(bus.wb_ack_o),   32'h0);
    chk("late_stall", 32'(bus.wb_stall_o), 32'h0);
    tick();
    chk("late_ack2",  32'(bus.wb_ack_o),   32'h0);

    // abort: cyc dropped at k=2, ack at k=3
    req(1'b0, 32'h1004, 32'h0, 4'hF);
    tick();
    bus.wb_cyc_i = 1'b0;
    tick();
    chk("ab_req", 32'(bus.reg_req_o), 32'h1);
    bus.reg_ack_i   = 1'b1;
    bus.reg_rdata_i = 32'h55;
    tick();
    bus.reg_ack_i   = 1'b0;
    chk("ab_ack", 32'(bus.wb_ack_o), 32'h0);
    chk("ab_err", 32'(bus.wb_err_o), 32'h0);
    tick();
    chk("ab_idle", 32'(bus.wb_stall_o), 32'h0);

    // reset in the middle of an access
    req(1'b0, 32'h1010, 32'h0, 4'hF);
    chk("mr_req1", 32'(bus.reg_req_o), 32'h1);
    rst = 1'b1;
    #1;
    chk("mr_req",   32'(bus.reg_req_o),  32'h0);
    chk("mr_stall", 32'(bus.wb_stall_o), 32'h0);
    tick();
    rst = 1'b0;
    bus.wb_cyc_i = 1'b0;
    tick();
    req(1'b1, 32'h1014, 32'hCAFE_0001, 4'h3);
    chk("pr_idx", 32'(bus.reg_idx_o), 32'h5);
    chk("pr_be",  32'(bus.reg_be_o),  32'h3);
    bus.reg_ack_i = 1'b1;
    tick();
    bus.reg_ack_i = 1'b0;
    chk("pr_ack", 32'(bus.wb_ack_o), 32'h1);
    tick();
    bus.wb_cyc_i = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
